// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S playback path: alignment word, read-FSM states
// and the default sample geometry.
package i2s_pkg;

  localparam int          SAMPLE_BITS      = 24;
  localparam int          BYTES_PER_SAMPLE = SAMPLE_BITS / 8;
  localparam logic [23:0] SYNC_WORD        = 24'hAAFF00;

  typedef enum logic [2:0] {
    SEARCH,
    S_REQ,
    S_CAP,
    L_REQ,
    L_CAP
  } rd_state_t;

endpackage

// File: rtl/i2s_playback_tx_serializer.sv
// I2S master serializer: bit-clock divider, frame bit counter, word select and
// sample shifter. Pulls one sample per frame through a sample/valid/consume handshake.
module i2s_tx_serializer #(
  parameter int DATA_SIZE = 24,
  parameter int CLK_DIV   = 64,
  parameter int SLOT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] sample_i,
  input  logic                 valid_i,
  output logic                 consume_o,
  output logic                 i2s_clk_o,
  output logic                 i2s_ws_o,
  output logic                 i2s_sd_o,
  output logic [7:0]           underrun_count_o
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] LAST_B = BW'(FRAME_BITS - 1);

  logic [DW-1:0]        div_q, div_d;
  logic                 sck_q, sck_d;
  logic [BW-1:0]        b_q, b_d;
  logic                 ws_q, ws_d;
  logic                 sd_q, sd_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] sample_q, sample_d;
  logic [7:0]           underrun_q, underrun_d;

  logic                 div_wrap;
  logic                 fall_evt;
  logic [BW-1:0]        b_next;
  logic [BW-1:0]        slot_pos;
  logic [DATA_SIZE-1:0] load;

  assign div_wrap = (div_q == DW'(CLK_DIV - 1));
  assign fall_evt = div_wrap && sck_q;
  assign b_next   = (b_q == LAST_B) ? '0 : b_q + 1'b1;
  assign slot_pos = (b_next >= BW'(SLOT_BITS)) ? b_next - BW'(SLOT_BITS) : b_next;
  assign load     = valid_i ? sample_i : '0;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    div_d      = div_wrap ? '0 : div_q + 1'b1;
    sck_d      = div_wrap ? ~sck_q : sck_q;
    b_d        = b_q;
    ws_d       = ws_q;
    sd_d       = sd_q;
    shift_d    = shift_q;
    sample_d   = sample_q;
    underrun_d = underrun_q;
    consume_o  = 1'b0;

    // Data and word select only move together with the falling bit-clock edge.
    if (fall_evt) begin
      b_d  = b_next;
      ws_d = !((b_next == LAST_B) || (b_next < BW'(SLOT_BITS - 1)));
      if (b_next == '0) begin
        sample_d  = load;
        consume_o = valid_i;
        if (!valid_i && underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
        sd_d    = load[DATA_SIZE-1];
        shift_d = {load[DATA_SIZE-2:0], 1'b0};
      end else if (b_next == BW'(SLOT_BITS)) begin
        sd_d    = sample_q[DATA_SIZE-1];
        shift_d = {sample_q[DATA_SIZE-2:0], 1'b0};
      end else if (slot_pos < BW'(DATA_SIZE)) begin
        sd_d    = shift_q[DATA_SIZE-1];
        shift_d = {shift_q[DATA_SIZE-2:0], 1'b0};
      end else begin
        sd_d = 1'b0;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      sck_q      <= 1'b0;
      b_q        <= LAST_B;  // first falling edge then lands on bit 0
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      shift_q    <= '0;
      sample_q   <= '0;
      underrun_q <= '0;
    end else begin
      div_q      <= div_d;
      sck_q      <= sck_d;
      b_q        <= b_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      shift_q    <= shift_d;
      sample_q   <= sample_d;
      underrun_q <= underrun_d;
    end
  end

  assign i2s_clk_o        = sck_q;
  assign i2s_ws_o         = ws_q;
  assign i2s_sd_o         = sd_q;
  assign underrun_count_o = underrun_q;

endmodule

// File: rtl/i2s_playback_tx.sv
// I2S playback top: aligns to the sync word in the FIFO byte stream, rebuilds
// samples into a one-deep holding register and hands them to the serializer.
module i2s_playback_tx #(
  parameter int                   DATA_SIZE = 24,
  parameter int                   CLK_DIV   = 64,
  parameter int                   SLOT_BITS = 32,
  parameter logic [DATA_SIZE-1:0] SYNC_WORD = i2s_pkg::SYNC_WORD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty_i,
  output logic       fifo_rd_en_o,
  input  logic [7:0] fifo_read_data_i,
  output logic       i2s_clk,
  output logic       i2s_ws,
  output logic       i2s_sd,
  output logic       locked_o,
  output logic [7:0] sync_count_o,
  output logic [7:0] underrun_count_o
);

  import i2s_pkg::*;

  localparam int         NBYTES     = DATA_SIZE / 8;
  localparam logic [1:0] LAST_PHASE = 2'(NBYTES - 1);

  rd_state_t            state_q, state_d;
  logic [DATA_SIZE-1:0] window_q, window_d;
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 locked_q, locked_d;
  logic [1:0]           phase_q, phase_d;
  logic [7:0]           sync_count_q, sync_count_d;
  logic                 rd_en;
  logic                 consume;
  logic [DATA_SIZE-1:0] window_shift;

  assign window_shift = {fifo_read_data_i, window_q[DATA_SIZE-1:8]};

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    locked_d     = locked_q;
    phase_d      = phase_q;
    sync_count_d = sync_count_q;
    rd_en        = 1'b0;

    // A write in L_CAP below overrides this, keeping the new sample valid.
    if (consume) hold_valid_d = 1'b0;

    unique case (state_q)
      SEARCH: begin
        if (window_q == SYNC_WORD) begin
          locked_d     = 1'b1;
          sync_count_d = sync_count_q + 8'd1;
          phase_d      = '0;
          state_d      = L_REQ;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!fifo_empty_i) begin
          rd_en   = 1'b1;
          state_d = S_CAP;
        end
      end
      S_CAP: begin
        window_d = window_shift;
        state_d  = SEARCH;
      end
      L_REQ: begin
        if (!fifo_empty_i && !hold_valid_q) begin
          rd_en   = 1'b1;
          state_d = L_CAP;
        end
      end
      L_CAP: begin
        window_d = window_shift;
        state_d  = L_REQ;
        if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          if (window_shift == SYNC_WORD) begin
            sync_count_d = sync_count_q + 8'd1;
          end else begin
            hold_d       = window_shift;
            hold_valid_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEARCH;
      window_q     <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      phase_q      <= '0;
      sync_count_q <= '0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      locked_q     <= locked_d;
      phase_q      <= phase_d;
      sync_count_q <= sync_count_d;
    end
  end

  i2s_tx_serializer #(
    .DATA_SIZE (DATA_SIZE),
    .CLK_DIV   (CLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_serializer (
    .clk              (clk),
    .rst              (rst),
    .sample_i         (hold_q),
    .valid_i          (hold_valid_q),
    .consume_o        (consume),
    .i2s_clk_o        (i2s_clk),
    .i2s_ws_o         (i2s_ws),
    .i2s_sd_o         (i2s_sd),
    .underrun_count_o (underrun_count_o)
  );

  assign fifo_rd_en_o = rd_en;
  assign locked_o     = locked_q;
  assign sync_count_o = sync_count_q;

endmodule

// File: tb/tb_i2s_playback_tx.sv
// Directed bench for i2s_playback_tx (CLK_DIV=4): byte FIFO model, I2S receiver
// model that rebuilds frames from the pins, table of samples plus corner sequences.
module tb_i2s_playback_tx;

  localparam int CLK_DIV = 4;
  localparam int LIMIT   = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty_i;
  logic       fifo_rd_en_o;
  logic [7:0] fifo_read_data_i = 8'h00;
  logic       i2s_clk, i2s_ws, i2s_sd, locked_o;
  logic [7:0] sync_count_o, underrun_count_o;

  i2s_playback_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_empty_i     (fifo_empty_i),
    .fifo_rd_en_o     (fifo_rd_en_o),
    .fifo_read_data_i (fifo_read_data_i),
    .i2s_clk          (i2s_clk),
    .i2s_ws           (i2s_ws),
    .i2s_sd           (i2s_sd),
    .locked_o         (locked_o),
    .sync_count_o     (sync_count_o),
    .underrun_count_o (underrun_count_o)
  );

  always #5 clk = ~clk;

  // Byte FIFO model: data appears the clock after the read pulse.
  logic [7:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty_i = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en_o && rd_ptr < wr_ptr) begin
      fifo_read_data_i <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  // I2S receiver model, sampled on the falling system clock.
  logic [31:0] frame_l [64];
  logic [31:0] frame_r [64];
  logic [31:0] cur_l = '0, cur_r = '0;
  int  frame_cnt = 0, mon_bit = 63, cyc = 0;
  int  rd_pulses = 0, rd_empty_err = 0, ws_err = 0, edge_err = 0, period_err = 0;
  bit  started = 0, have_rise = 0;
  logic prev_sck = 1'b0, prev_ws = 1'b0, prev_sd = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_bit   = 63;
      started   = 0;
      frame_cnt = 0;
      have_rise = 0;
      cyc       = 0;
    end else begin
      cyc++;
      if (fifo_rd_en_o) begin
        rd_pulses++;
        if (fifo_empty_i) rd_empty_err++;
      end
      if ((i2s_ws !== prev_ws || i2s_sd !== prev_sd) && !(prev_sck && !i2s_clk)) edge_err++;
      if (prev_sck && !i2s_clk) begin
        mon_bit = (mon_bit == 63) ? 0 : mon_bit + 1;
        started = 1;
      end
      if (!prev_sck && i2s_clk) begin
        if (have_rise && cyc != 2 * CLK_DIV) period_err++;
        have_rise = 1;
        cyc       = 0;
        if (started) begin
          if (i2s_ws !== ((mon_bit == 63 || mon_bit < 31) ? 1'b0 : 1'b1)) ws_err++;
          if (mon_bit < 32) cur_l = {cur_l[30:0], i2s_sd};
          else              cur_r = {cur_r[30:0], i2s_sd};
          if (mon_bit == 63 && frame_cnt < 64) begin
            frame_l[frame_cnt] = cur_l;
            frame_r[frame_cnt] = cur_r;
            frame_cnt++;
          end
        end
      end
    end
    prev_sck = i2s_clk;
    prev_ws  = i2s_ws;
    prev_sd  = i2s_sd;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame_done(input int n);
    int t = 0;
    while (frame_cnt < n && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (frame_cnt < n) check("timeout_frame_done", 64'(frame_cnt), 64'(n));
  endtask

  task automatic wait_frame_start(input int n);
    int t = 0;
    while (!(frame_cnt >= n && mon_bit != 63) && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (frame_cnt < n) check("timeout_frame_start", 64'(frame_cnt), 64'(n));
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [23:0] sample;
    int          consumed;  // bytes read mid-way through this sample's frame
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [63:0] acc;
    int base;
    int t;

    vecs[0] = '{8'hA1, 8'hB2, 8'hC3, 24'hC3B2A1, 6};
    vecs[1] = '{8'hFF, 8'hFF, 8'h7F, 24'h7FFFFF, 9};
    vecs[2] = '{8'h01, 8'h00, 8'h80, 24'h800001, 12};
    vecs[3] = '{8'h00, 8'hFF, 8'hAB, 24'hABFF00, 12};

    repeat (3) @(negedge clk);
    check("reset_pins", {60'd0, i2s_clk, i2s_ws, i2s_sd, fifo_rd_en_o}, 64'd0);
    check("reset_locked", {63'd0, locked_o}, 64'd0);
    check("reset_counts", {48'd0, sync_count_o, underrun_count_o}, 64'd0);
    rst = 1'b0;

    // Underrun: empty FIFO for three frames.
    wait_frame_done(3);
    check("underrun_count", {56'd0, underrun_count_o}, 64'd3);
    acc = '0;
    for (int i = 0; i < 3; i++) acc |= {frame_l[i], frame_r[i]};
    check("underrun_sd_silent", acc, 64'd0);
    check("underrun_no_rd_en", 64'(rd_pulses), 64'd0);

    // Alignment: leading 0x12 is thrown away, 0x123456 plays in frame 4.
    wait_frame_start(3);
    push(8'h12); push(8'h00); push(8'hFF); push(8'hAA);
    push(8'h56); push(8'h34); push(8'h12);
    wait_frame_done(5);
    check("align_left", {32'd0, frame_l[4]}, 64'h12345600);
    check("align_right", {32'd0, frame_r[4]}, 64'h12345600);
    check("align_locked", {63'd0, locked_o}, 64'd1);
    check("align_sync_count", {56'd0, sync_count_o}, 64'd1);
    check("align_underrun", {56'd0, underrun_count_o}, 64'd4);
    check("align_bytes_read", 64'(rd_ptr), 64'(wr_ptr));

    // Sample table, all queued at once: one sample per frame, held back by the holding register.
    wait_frame_start(5);
    base = wr_ptr;
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].b0); push(vecs[i].b1); push(vecs[i].b2);
    end
    for (int i = 0; i < 4; i++) begin
      wait_frame_start(6 + i);
      repeat (40) @(negedge clk);
      check($sformatf("bp_bytes_read_%0d", i), 64'(rd_ptr - base), 64'(vecs[i].consumed));
      wait_frame_done(7 + i);
      check($sformatf("vec_left_%0d", i), {32'd0, frame_l[6 + i]}, {32'd0, vecs[i].sample, 8'h00});
      check($sformatf("vec_right_%0d", i), {32'd0, frame_r[6 + i]}, {32'd0, vecs[i].sample, 8'h00});
    end
    check("vec_underrun", {56'd0, underrun_count_o}, 64'd5);

    // Sync strip inside a locked stream.
    wait_frame_start(10);
    push(8'h01); push(8'h02); push(8'h03);
    push(8'h00); push(8'hFF); push(8'hAA);
    push(8'h04); push(8'h05); push(8'h06);
    wait_frame_done(13);
    check("strip_first", {frame_l[11], frame_r[11]}, {32'h03020100, 32'h03020100});
    check("strip_second", {frame_l[12], frame_r[12]}, {32'h06050400, 32'h06050400});
    check("strip_sync_count", {56'd0, sync_count_o}, 64'd2);
    check("strip_underrun", {56'd0, underrun_count_o}, 64'd6);

    // Reset at bit 40 with a partially filled window.
    wait_frame_start(13);
    push(8'hDE); push(8'hAD);
    t = 0;
    while (!(frame_cnt == 13 && mon_bit == 40) && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check("reach_bit_40", 64'(mon_bit), 64'd40);
    #2 rst = 1'b1;
    #1;
    check("midreset_pins", {60'd0, i2s_clk, i2s_ws, i2s_sd, fifo_rd_en_o}, 64'd0);
    check("midreset_locked", {63'd0, locked_o}, 64'd0);
    check("midreset_counts", {48'd0, sync_count_o, underrun_count_o}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Without a fresh sync word nothing may play.
    push(8'h11); push(8'h22); push(8'h33);
    wait_frame_done(2);
    check("resync_silent", {frame_l[0] | frame_l[1], frame_r[0] | frame_r[1]}, 64'd0);
    check("resync_unlocked", {63'd0, locked_o}, 64'd0);
    check("resync_bytes_read", 64'(rd_ptr), 64'(wr_ptr));
    check("resync_underrun", {56'd0, underrun_count_o}, 64'd2);

    wait_frame_start(2);
    push(8'h00); push(8'hFF); push(8'hAA);
    push(8'h77); push(8'h88); push(8'h99);
    wait_frame_done(4);
    check("relock_sample", {frame_l[3], frame_r[3]}, {32'h99887700, 32'h99887700});
    check("relock_locked", {63'd0, locked_o}, 64'd1);
    check("relock_sync_count", {56'd0, sync_count_o}, 64'd1);
    check("relock_underrun", {56'd0, underrun_count_o}, 64'd3);

    // Pin-timing rules accumulated by the receiver model over the whole run.
    check("ws_pattern_errors", 64'(ws_err), 64'd0);
    check("change_off_fall_edge", 64'(edge_err), 64'd0);
    check("sck_period_errors", 64'(period_err), 64'd0);
    check("rd_en_while_empty", 64'(rd_empty_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
